// File: rtl/clb_pkg.sv
// clb_pkg: shared constants for the CLB column pipeline.
// Window geometry, cell count and occupancy encoding.
package clb_pkg;

   localparam int CLB_WIDTH  = 32;
   localparam int CLB_NSLOT  = 8;
   localparam int CLB_NCELL  = 4;
   localparam int CLB_SLOT_W = 3;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/clb_slot_merge.sv
// clb_slot_merge: combinational merge of one window slot.
// Ports: win (carry value), res0..3 (cell results),
//        wen (steer enables), dst0..3 (slot per result),
//        slot (this slot's index) -> val (merged value),
//        hits (number of enabled results aimed here).
module clb_slot_merge
   import clb_pkg::*;
#(
   parameter int WIDTH = CLB_WIDTH
) (
   input  logic [WIDTH-1:0]      win,
   input  logic [WIDTH-1:0]      res0,
   input  logic [WIDTH-1:0]      res1,
   input  logic [WIDTH-1:0]      res2,
   input  logic [WIDTH-1:0]      res3,
   input  logic [CLB_NCELL-1:0]  wen,
   input  logic [CLB_SLOT_W-1:0] dst0,
   input  logic [CLB_SLOT_W-1:0] dst1,
   input  logic [CLB_SLOT_W-1:0] dst2,
   input  logic [CLB_SLOT_W-1:0] dst3,
   input  logic [CLB_SLOT_W-1:0] slot,
   output logic [WIDTH-1:0]      val,
   output logic [2:0]            hits
);

   logic [WIDTH-1:0]      res_a [CLB_NCELL];
   logic [CLB_SLOT_W-1:0] dst_a [CLB_NCELL];

   assign res_a[0] = res0;
   assign res_a[1] = res1;
   assign res_a[2] = res2;
   assign res_a[3] = res3;
   assign dst_a[0] = dst0;
   assign dst_a[1] = dst1;
   assign dst_a[2] = dst2;
   assign dst_a[3] = dst3;

   // Scan from the highest cell down so the
   // lowest-numbered matching result wins.
   always_comb begin
      val  = win;
      hits = '0;
      for (int i = CLB_NCELL - 1; i >= 0; i--) begin
         if (wen[i] && (dst_a[i] == slot)) begin
            val  = res_a[i];
            hits = hits + 3'd1;
         end
      end
   end

endmodule

// File: rtl/clb_column_pipe.sv
// clb_column_pipe: merge a CLB column's results into the
// next operand window, registered with a 2-deep skid.
// Ports: clk, rst_n (sync, active-low)
//   in : win0..7, res0..3, wen, dst0..3, in_valid
//   out: in_ready, op0..7, out_valid (out_ready in)
//   collide (sticky slot collision), collide_clr
module clb_column_pipe
   import clb_pkg::*;
#(
   parameter int WIDTH = CLB_WIDTH,
   parameter int NSLOT = CLB_NSLOT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      win0,
   input  logic [WIDTH-1:0]      win1,
   input  logic [WIDTH-1:0]      win2,
   input  logic [WIDTH-1:0]      win3,
   input  logic [WIDTH-1:0]      win4,
   input  logic [WIDTH-1:0]      win5,
   input  logic [WIDTH-1:0]      win6,
   input  logic [WIDTH-1:0]      win7,
   input  logic [WIDTH-1:0]      res0,
   input  logic [WIDTH-1:0]      res1,
   input  logic [WIDTH-1:0]      res2,
   input  logic [WIDTH-1:0]      res3,
   input  logic [CLB_NCELL-1:0]  wen,
   input  logic [CLB_SLOT_W-1:0] dst0,
   input  logic [CLB_SLOT_W-1:0] dst1,
   input  logic [CLB_SLOT_W-1:0] dst2,
   input  logic [CLB_SLOT_W-1:0] dst3,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [WIDTH-1:0]      op0,
   output logic [WIDTH-1:0]      op1,
   output logic [WIDTH-1:0]      op2,
   output logic [WIDTH-1:0]      op3,
   output logic [WIDTH-1:0]      op4,
   output logic [WIDTH-1:0]      op5,
   output logic [WIDTH-1:0]      op6,
   output logic [WIDTH-1:0]      op7,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  collide,
   input  logic                  collide_clr
);

   logic [WIDTH-1:0] win_a  [NSLOT];
   logic [WIDTH-1:0] mrg    [NSLOT];
   logic [WIDTH-1:0] main_q [NSLOT];
   logic [WIDTH-1:0] skid_q [NSLOT];
   logic [2:0]       hits   [NSLOT];
   logic [NSLOT-1:0] multi;
   logic [1:0]       occ;
   logic             in_xfer;
   logic             out_xfer;
   logic             coll_hit;

   assign win_a[0] = win0;
   assign win_a[1] = win1;
   assign win_a[2] = win2;
   assign win_a[3] = win3;
   assign win_a[4] = win4;
   assign win_a[5] = win5;
   assign win_a[6] = win6;
   assign win_a[7] = win7;

   for (genvar k = 0; k < NSLOT; k++) begin : g_slot
      clb_slot_merge #(
         .WIDTH (WIDTH)
      ) u_merge (
         .win  (win_a[k]),
         .res0 (res0),
         .res1 (res1),
         .res2 (res2),
         .res3 (res3),
         .wen  (wen),
         .dst0 (dst0),
         .dst1 (dst1),
         .dst2 (dst2),
         .dst3 (dst3),
         .slot (CLB_SLOT_W'(k)),
         .val  (mrg[k]),
         .hits (hits[k])
      );
      assign multi[k] = (hits[k] > 3'd1);
   end

   // Any slot hit twice means some pair collided.
   assign coll_hit = |multi;

   // Handshake flags decode straight from the
   // occupancy register: no input-to-output path.
   assign in_ready  = (occ != OCC_TWO);
   assign out_valid = (occ != OCC_EMPTY);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ    <= OCC_EMPTY;
         main_q <= '{default: '0};
         skid_q <= '{default: '0};
      end else begin
         unique case (1'b1)
            (occ == OCC_EMPTY): begin
               if (in_xfer) begin
                  main_q <= mrg;
                  occ    <= OCC_ONE;
               end
            end
            (occ == OCC_ONE): begin
               if (in_xfer && out_xfer) begin
                  main_q <= mrg;
               end else if (in_xfer) begin
                  skid_q <= mrg;
                  occ    <= OCC_TWO;
               end else if (out_xfer) begin
                  occ <= OCC_EMPTY;
               end
            end
            (occ == OCC_TWO): begin
               if (out_xfer) begin
                  main_q <= skid_q;
                  occ    <= OCC_ONE;
               end
            end
            default: occ <= OCC_EMPTY;
         endcase
      end
   end

   // A new collision beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         collide <= 1'b0;
      end else if (in_xfer && coll_hit) begin
         collide <= 1'b1;
      end else if (collide_clr) begin
         collide <= 1'b0;
      end
   end

   assign op0 = main_q[0];
   assign op1 = main_q[1];
   assign op2 = main_q[2];
   assign op3 = main_q[3];
   assign op4 = main_q[4];
   assign op5 = main_q[5];
   assign op6 = main_q[6];
   assign op7 = main_q[7];

endmodule

// File: tb/tb_clb_column_pipe.sv
// tb_clb_column_pipe: randomized bench for clb_column_pipe
// against a queue-based reference model.
module tb_clb_column_pipe;

   typedef logic [255:0] word_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] win [8];
   logic [31:0] res [4];
   logic [31:0] op  [8];
   logic [2:0]  dst [4];
   logic [3:0]  wen;
   logic        in_valid, in_ready;
   logic        out_valid, out_ready;
   logic        collide, collide_clr;

   int    checks = 0;
   int    errs   = 0;
   word_t q[$];
   bit    m_collide;
   bit    last_ix, last_ox;
   int    nout;

   always #5 clk = ~clk;

   clb_column_pipe u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .win0        (win[0]),
      .win1        (win[1]),
      .win2        (win[2]),
      .win3        (win[3]),
      .win4        (win[4]),
      .win5        (win[5]),
      .win6        (win[6]),
      .win7        (win[7]),
      .res0        (res[0]),
      .res1        (res[1]),
      .res2        (res[2]),
      .res3        (res[3]),
      .wen         (wen),
      .dst0        (dst[0]),
      .dst1        (dst[1]),
      .dst2        (dst[2]),
      .dst3        (dst[3]),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op0         (op[0]),
      .op1         (op[1]),
      .op2         (op[2]),
      .op3         (op[3]),
      .op4         (op[4]),
      .op5         (op[5]),
      .op6         (op[6]),
      .op7         (op[7]),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .collide     (collide),
      .collide_clr (collide_clr)
   );

   task automatic chk(input string tag,
                      input word_t got,
                      input word_t exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
      end
   endtask

   function automatic word_t dut_word();
      word_t w;
      for (int k = 0; k < 8; k++) w[k*32 +: 32] = op[k];
      return w;
   endfunction

   // Expected window: first enabled result (cell 0
   // upward) naming the slot, else the carried operand.
   function automatic word_t ref_merge();
      word_t w;
      for (int k = 0; k < 8; k++) begin
         bit found = 0;
         w[k*32 +: 32] = win[k];
         for (int i = 0; i < 4; i++) begin
            if (!found && wen[i] && dst[i] == 3'(k)) begin
               w[k*32 +: 32] = res[i];
               found = 1;
            end
         end
      end
      return w;
   endfunction

   function automatic bit ref_collide();
      for (int i = 0; i < 4; i++)
         for (int j = i + 1; j < 4; j++)
            if (wen[i] && wen[j] && dst[i] == dst[j])
               return 1;
      return 0;
   endfunction

   task automatic cycle();
      bit    ix, ox, cl;
      word_t exp;
      @(negedge clk);
      chk("out_valid", word_t'(out_valid),
          word_t'(q.size() > 0));
      chk("in_ready", word_t'(in_ready),
          word_t'(q.size() < 2));
      chk("collide", word_t'(collide), word_t'(m_collide));
      if (q.size() > 0) chk("op", dut_word(), q[0]);
      ix  = rst_n && in_valid && (q.size() < 2);
      ox  = rst_n && out_ready && (q.size() > 0);
      exp = ref_merge();
      cl  = ref_collide();
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
         m_collide = 0;
      end else begin
         if (ox) void'(q.pop_front());
         if (ix) q.push_back(exp);
         if (ix && cl) m_collide = 1;
         else if (collide_clr) m_collide = 0;
      end
      last_ix = ix;
      last_ox = ox;
      #1;
   endtask

   task automatic rand_data();
      for (int k = 0; k < 8; k++) win[k] = $urandom;
      for (int i = 0; i < 4; i++) begin
         res[i] = $urandom;
         dst[i] = 3'($urandom_range(7));
      end
      wen = 4'($urandom);
   endtask

   initial begin
      rst_n = 0; in_valid = 0; out_ready = 0;
      collide_clr = 0; wen = '0;
      for (int k = 0; k < 8; k++) win[k] = '0;
      for (int i = 0; i < 4; i++) begin
         res[i] = '0; dst[i] = '0;
      end
      m_collide = 0;
      #1;
      cycle(); cycle();
      rst_n = 1;
      chk("rst_out_valid", word_t'(out_valid), 0);
      chk("rst_in_ready", word_t'(in_ready), 1);
      chk("rst_op", dut_word(), 0);

      // Pass-through.
      for (int k = 0; k < 8; k++) win[k] = 32'h10 + k;
      in_valid = 1; out_ready = 1;
      cycle();
      in_valid = 0;
      chk("pt_valid", word_t'(out_valid), 1);
      for (int k = 0; k < 8; k++)
         chk("pt_op", word_t'(op[k]), word_t'(32'h10 + k));
      cycle();
      chk("pt_one_cycle", word_t'(out_valid), 0);

      // Steering with a collision on slot 3.
      res[0] = 32'hA0; res[1] = 32'hA1;
      res[2] = 32'hA2; res[3] = 32'hA3;
      dst[0] = 7; dst[1] = 0; dst[2] = 3; dst[3] = 3;
      wen = 4'b1111; in_valid = 1;
      cycle();
      in_valid = 0;
      chk("st_op7", word_t'(op[7]), 32'hA0);
      chk("st_op0", word_t'(op[0]), 32'hA1);
      chk("st_op3", word_t'(op[3]), 32'hA2);
      chk("st_op1", word_t'(op[1]), 32'h11);
      chk("st_op5", word_t'(op[5]), 32'h15);
      chk("st_coll", word_t'(collide), 1);
      cycle();
      chk("st_sticky", word_t'(collide), 1);
      collide_clr = 1;
      cycle();
      collide_clr = 0;
      chk("st_clr", word_t'(collide), 0);

      // Backpressure: W1, W2 accepted, W3 held off.
      out_ready = 0; wen = '0; in_valid = 1;
      win[0] = 32'h101; cycle();
      win[0] = 32'h102; cycle();
      chk("bp_full", word_t'(in_ready), 0);
      win[0] = 32'h103; cycle(); cycle();
      chk("bp_held", word_t'(last_ix), 0);
      out_ready = 1; nout = 0;
      for (int c = 0; c < 6; c++) begin
         cycle();
         if (last_ix) in_valid = 0;
         if (last_ox) nout++;
      end
      chk("bp_count", word_t'(nout), 3);

      // Full throughput.
      nout = 0; in_valid = 1;
      for (int c = 0; c < 17; c++) begin
         win[0] = 32'h200 + c;
         if (c == 16) in_valid = 0;
         cycle();
         if (last_ox) nout++;
      end
      chk("ft_count", word_t'(nout), 16);

      // Reset while full.
      out_ready = 0; in_valid = 1;
      wen = 4'b0011; dst[0] = 2; dst[1] = 2;
      cycle();
      wen = '0; cycle();
      in_valid = 0; rst_n = 0;
      cycle();
      rst_n = 1;
      chk("mr_valid", word_t'(out_valid), 0);
      chk("mr_ready", word_t'(in_ready), 1);
      chk("mr_op", dut_word(), 0);
      chk("mr_coll", word_t'(collide), 0);
      in_valid = 1; win[0] = 32'h300;
      cycle();
      in_valid = 0;
      chk("mr_lat", word_t'(out_valid), 1);
      chk("mr_data", word_t'(op[0]), 32'h300);

      // Random handshake.
      rand_data();
      for (int c = 0; c < 1000; c++) begin
         if (!(in_valid && !last_ix)) begin
            rand_data();
            in_valid = ($urandom_range(3) != 0);
         end
         out_ready   = ($urandom_range(2) != 0);
         collide_clr = ($urandom_range(7) == 0);
         cycle();
      end
      in_valid = 0; out_ready = 1; collide_clr = 0;
      for (int c = 0; c < 4; c++) cycle();
      chk("drain", word_t'(out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errs);
      $finish;
   end

endmodule

// File: doc/clb_column_pipe.md
Name: clb_column_pipe

Overview:
- Pipeline stage directly downstream of a CLB column: captures the column's four cell results and its eight-operand input window, then builds the next column's eight-operand window.
- Each result is steered into a chosen slot of the outgoing window; slots that receive no result carry the incoming operand forward unchanged.
- Registered with a valid/ready handshake and a 2-entry skid buffer, so columns can be chained at full throughput under backpressure.

Parameters:
- WIDTH, 32, operand/result data width in bits
- NSLOT, 8, operand window slots (fixed at 8; the 3-bit slot index depends on it)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- win0..win7  in  WIDTH each  operand window the upstream column consumed (carry-through values)
- res0..res3  in  WIDTH each  cell results from the upstream column (res0 = cell_0 ... res3 = cell_3)
- wen  in  4  per-result steer enable; bit i gates res_i
- dst0..dst3  in  3 each  destination slot index for res_i
- in_valid  in  1  upstream data/config valid
- in_ready  out  1  stage can accept
- op0..op7  out  WIDTH each  operand window for the downstream column
- out_valid  out  1  op0..op7 valid
- out_ready  in  1  downstream accepts
- collide  out  1  sticky: two enabled results targeted the same slot
- collide_clr  in  1  clears collide

Behaviour:
- Merge, combinational: for each slot k, op_next[k] = res_i for the lowest i with wen[i]=1 and dst_i==k; otherwise win_k.
  - Priority is res0 > res1 > res2 > res3.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Upstream may change inputs only after a transfer; the stage samples only on an input transfer.
- Main register and latency:
  - Main register holds the presented window.
  - Latency is 1 cycle: a word accepted at edge N appears on op* with out_valid=1 after edge N.
- Skid register:
  - Holds one extra merged word.
  - in_ready = !skid_full (registered, no combinational in_ready/out_ready path).
- Occupancy states and transitions:
  - EMPTY: out_valid=0, in_ready=1. Input transfer -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Input and output transfer together -> ONE, main reloads.
    - Input only -> TWO, word goes to skid.
    - Output only -> EMPTY.
  - TWO: out_valid=1, in_ready=0.
    - Output transfer -> ONE, skid moves to main.
    - No input is accepted in TWO.
- Ordering: strict FIFO; no word is lost or duplicated under any in_valid/out_ready pattern.
- Collision detection:
  - Evaluated only on an input transfer.
  - Any pair i<j with wen[i]&wen[j]&(dst_i==dst_j) sets collide on the following edge.
  - collide stays set until collide_clr=1 or reset.
  - collide_clr and a new collision in the same cycle: set wins.
- wen=0000: window passes through unmodified (pure delay stage).
- Reset (rst_n=0 sampled at an edge), including mid-transfer:
  - State -> EMPTY; out_valid=0, in_ready=1, collide=0.
  - op0..op7 = 0; skid data = 0.
  - Words in flight are discarded.
  - in_ready is 1 in the first cycle after reset deasserts.
- Data registers load only on a transfer; op* is stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package clb_pkg:
  - CLB_WIDTH=32, CLB_NSLOT=8, CLB_NCELL=4, CLB_SLOT_W=3.
  - Occupancy encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- Sub-module clb_slot_merge: purely combinational merge of one slot (win_k, res0..3, wen, dst0..3, slot index k -> value, hit count).
  - Instantiated 8 times.
  - The parent ORs "hit count > 1" across slots to form the collision strobe.

Test Plan:
- Pass-through: win0..7 = 0x10..0x17, wen=0000, out_ready=1 -> after one cycle op0..7 = 0x10..0x17, out_valid=1 for exactly one cycle.
- Steering: res0=0xA0, res1=0xA1, res2=0xA2, res3=0xA3; dst0=7, dst1=0, dst2=3, dst3=3; wen=1111 -> op7=0xA0, op0=0xA1, op3=0xA2, other slots = win, collide=1 sticky; pulse collide_clr -> collide=0 next cycle.
- Backpressure: hold out_ready=0, send words W1, W2, W3 -> W1 and W2 accepted, in_ready=0 from the cycle after W2; raise out_ready -> outputs W1, W2, W3 in order with no gaps once streaming.
- Full throughput: in_valid=1 and out_ready=1 for 16 cycles with an incrementing win0 -> 16 consecutive outputs, in_ready never 0.
- Reset mid-operation: enter TWO (out_ready=0, two words), assert rst_n=0 for one edge -> out_valid=0, in_ready=1, op*=0, collide=0; the next input appears with latency 1.
- Random handshake: random in_valid/out_ready for 1000 cycles with a scoreboard -> every accepted word emerges once, in order, correctly merged.
